// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter: scoreboard tag width,
// exception record and the packed per-source result payload.
package wb_port_arbiter_pkg;

  localparam int TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              data;
    exception_t               ex;
  } wb_req_t;

  // Pointer width that stays legal for a single-entry vector.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Result-source request bundle and registered writeback bundle between the
// execute-stage units (master) and the writeback port arbiter (slave).
interface wb_port_arbiter_if #(
  parameter int NR_REQ      = 6,
  parameter int NR_WB_PORTS = 4
);
  import wb_port_arbiter_pkg::*;

  logic       [NR_REQ-1:0]                          req_valid;
  logic       [NR_REQ-1:0]                          req_ready;
  logic       [NR_REQ-1:0][TRANS_ID_BITS-1:0]       req_trans_id;
  logic       [NR_REQ-1:0][63:0]                    req_data;
  exception_t [NR_REQ-1:0]                          req_ex;

  logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]  trans_id;
  logic       [NR_WB_PORTS-1:0][63:0]               wbdata;
  exception_t [NR_WB_PORTS-1:0]                     ex;
  logic       [NR_WB_PORTS-1:0]                     wb_valid;

  modport master (
    output req_valid, req_trans_id, req_data, req_ex,
    input  req_ready, trans_id, wbdata, ex, wb_valid
  );

  modport slave (
    input  req_valid, req_trans_id, req_data, req_ex,
    output req_ready, trans_id, wbdata, ex, wb_valid
  );

endinterface

// File: rtl/wb_port_arbiter_rr_pick.sv
// Round-robin selector: scans sources starting at rr_ptr (wrapping at NR_REQ)
// and assigns the first NR_WB_PORTS valid ones to ports 0, 1, ... in order.
module wb_rr_pick #(
  parameter int NR_REQ      = 6,
  parameter int NR_WB_PORTS = 4,
  parameter int PTR_W       = 3
) (
  input  logic [NR_REQ-1:0]                  valid,
  input  logic [PTR_W-1:0]                   rr_ptr,
  output logic [NR_REQ-1:0]                  grant,
  output logic [NR_WB_PORTS-1:0][PTR_W-1:0]  port_idx,
  output logic [NR_WB_PORTS-1:0]             port_hit,
  output logic [PTR_W-1:0]                   last_idx
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  int               cnt;

  always_comb begin
    grant    = '0;
    port_idx = '0;
    port_hit = '0;
    last_idx = rr_ptr;
    sum      = '0;
    idx      = '0;
    cnt      = 0;
    for (int j = 0; j < NR_REQ; j++) begin
      // Modulo by subtraction so non-power-of-2 source counts wrap correctly.
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
      if (sum >= (PTR_W+1)'(NR_REQ)) sum = sum - (PTR_W+1)'(NR_REQ);
      idx = sum[PTR_W-1:0];
      if (valid[idx] && (cnt < NR_WB_PORTS)) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < NR_WB_PORTS; k++) begin
          if (k == cnt) begin
            port_idx[k] = idx;
            port_hit[k] = 1'b1;
          end
        end
        last_idx = idx;
        cnt      = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares NR_WB_PORTS scoreboard writeback ports among NR_REQ result sources
// with round-robin grants; granted payloads are registered onto the ports.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NR_REQ      = 6,
  parameter int NR_WB_PORTS = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  wb_port_arbiter_if.slave bus
);

  localparam int PTR_W = ptr_width(NR_REQ);

  logic [PTR_W-1:0]                  rr_ptr;
  logic [PTR_W-1:0]                  last_idx;
  logic [NR_REQ-1:0]                 grant;
  logic [NR_WB_PORTS-1:0][PTR_W-1:0] port_idx;
  logic [NR_WB_PORTS-1:0]            port_hit;
  logic                              accept;
  wb_req_t [NR_REQ-1:0]              req;
  wb_req_t [NR_WB_PORTS-1:0]         port_req;

  wb_rr_pick #(
    .NR_REQ      (NR_REQ),
    .NR_WB_PORTS (NR_WB_PORTS),
    .PTR_W       (PTR_W)
  ) u_pick (
    .valid    (bus.req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_idx (port_idx),
    .port_hit (port_hit),
    .last_idx (last_idx)
  );

  // Reset and flush suppress the handshake in the same cycle.
  assign accept        = ~rst_i & ~flush_i;
  assign bus.req_ready = accept ? grant : '0;

  always_comb begin
    for (int i = 0; i < NR_REQ; i++) begin
      req[i].trans_id = bus.req_trans_id[i];
      req[i].data     = bus.req_data[i];
      req[i].ex       = bus.req_ex[i];
    end
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      port_req[k] = req[port_idx[k]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr       <= '0;
      bus.wb_valid <= '0;
      bus.trans_id <= '0;
      bus.wbdata   <= '0;
      bus.ex       <= '0;
    end else if (flush_i) begin
      bus.wb_valid <= '0;
    end else begin
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        bus.wb_valid[k] <= port_hit[k];
        // Idle ports keep their last payload; only valid is cleared.
        if (port_hit[k]) begin
          bus.trans_id[k] <= port_req[k].trans_id;
          bus.wbdata[k]   <= port_req[k].data;
          bus.ex[k]       <= port_req[k].ex;
        end
      end
      if (port_hit[0]) begin
        rr_ptr <= (last_idx == PTR_W'(NR_REQ-1)) ? '0 : last_idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter followed by a randomized starvation and
// result-scoreboard run with source 2 held valid.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int NR_REQ      = 6;
  localparam int NR_WB_PORTS = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  wb_port_arbiter_if #(.NR_REQ(NR_REQ), .NR_WB_PORTS(NR_WB_PORTS)) bus ();

  wb_port_arbiter #(.NR_REQ(NR_REQ), .NR_WB_PORTS(NR_WB_PORTS)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sources in mask present trans_id=i, data=100+i, no exception.
  task automatic drive_all(input logic [NR_REQ-1:0] m);
    for (int i = 0; i < NR_REQ; i++) begin
      bus.req_valid[i]    = m[i];
      bus.req_trans_id[i] = TRANS_ID_BITS'(i);
      bus.req_data[i]     = 64'(100 + i);
      bus.req_ex[i]       = '0;
    end
  endtask

  logic [NR_REQ-1:0] v;
  logic [NR_REQ-1:0] r;
  logic [63:0]       d [NR_REQ];
  logic [63:0]       exp_q [$];
  int seq, nv, n, streak, max_streak;
  int bad_ready, bad_count, bad_ports, unexpected, lost;
  bit found;

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive_all('1);

    // Reset with everything valid
    @(negedge clk_i); #1;
    check("rst_ready", bus.req_ready, 64'h0);
    @(posedge clk_i); #1;
    check("rst_wb_valid", bus.wb_valid, 64'h0);
    check("rst_rr_ptr", dut.rr_ptr, 64'h0);
    check("rst_trans_id", bus.trans_id, 64'h0);
    check("rst_wbdata0", bus.wbdata[0], 64'h0);

    // Saturation cycle 1
    @(negedge clk_i); rst_i = 1'b0; drive_all('1); #1;
    check("sat1_ready", bus.req_ready, 64'b001111);
    @(posedge clk_i); #1;
    check("sat1_wb_valid", bus.wb_valid, 64'hF);
    check("sat1_wbdata0", bus.wbdata[0], 64'd100);
    check("sat1_wbdata3", bus.wbdata[3], 64'd103);
    check("sat1_trans_id3", bus.trans_id[3], 64'd3);
    check("sat1_rr_ptr", dut.rr_ptr, 64'd4);

    // Saturation cycle 2: wrap 4,5,0,1
    @(negedge clk_i); drive_all('1); #1;
    check("sat2_ready", bus.req_ready, 64'b110011);
    @(posedge clk_i); #1;
    check("sat2_wbdata0", bus.wbdata[0], 64'd104);
    check("sat2_wbdata1", bus.wbdata[1], 64'd105);
    check("sat2_wbdata2", bus.wbdata[2], 64'd100);
    check("sat2_wbdata3", bus.wbdata[3], 64'd101);
    check("sat2_rr_ptr", dut.rr_ptr, 64'd2);

    // Sparse: only source 5
    @(negedge clk_i); drive_all(6'b100000);
    bus.req_trans_id[5] = 3'd3; bus.req_data[5] = 64'hDEAD; #1;
    check("sparse_ready", bus.req_ready, 64'b100000);
    @(posedge clk_i); #1;
    check("sparse_wb_valid", bus.wb_valid, 64'b0001);
    check("sparse_trans_id0", bus.trans_id[0], 64'd3);
    check("sparse_wbdata0", bus.wbdata[0], 64'hDEAD);
    check("sparse_hold_wbdata1", bus.wbdata[1], 64'd105);
    check("sparse_rr_ptr", dut.rr_ptr, 64'd0);

    // Idle cycle
    @(negedge clk_i); drive_all('0); #1;
    check("idle_ready", bus.req_ready, 64'h0);
    @(posedge clk_i); #1;
    check("idle_wb_valid", bus.wb_valid, 64'h0);
    check("idle_hold_wbdata0", bus.wbdata[0], 64'hDEAD);
    check("idle_rr_ptr", dut.rr_ptr, 64'd0);

    // Move rr_ptr to 4, then flush
    @(negedge clk_i); drive_all('1); #1;
    check("preflush_ready", bus.req_ready, 64'b001111);
    @(posedge clk_i); #1;
    check("preflush_rr_ptr", dut.rr_ptr, 64'd4);
    @(negedge clk_i); flush_i = 1'b1; drive_all('1); #1;
    check("flush_ready", bus.req_ready, 64'h0);
    @(posedge clk_i); #1;
    check("flush_wb_valid", bus.wb_valid, 64'h0);
    check("flush_rr_ptr", dut.rr_ptr, 64'd4);
    @(negedge clk_i); flush_i = 1'b0; drive_all('1); #1;
    check("postflush_ready", bus.req_ready, 64'b110011);
    @(posedge clk_i); #1;
    check("postflush_wbdata0", bus.wbdata[0], 64'd104);
    check("postflush_rr_ptr", dut.rr_ptr, 64'd2);

    // Exception passthrough from source 1
    @(negedge clk_i); drive_all(6'b000010);
    bus.req_ex[1].cause = 64'd5; bus.req_ex[1].valid = 1'b1; #1;
    check("ex_ready", bus.req_ready, 64'b000010);
    @(posedge clk_i); #1;
    check("ex_wb_valid", bus.wb_valid, 64'b0001);
    check("ex_valid0", bus.ex[0].valid, 64'd1);
    check("ex_cause0", bus.ex[0].cause, 64'd5);
    check("ex_trans_id0", bus.trans_id[0], 64'd1);

    // Fewer valid than ports, wrapping from rr_ptr=2
    @(negedge clk_i); drive_all(6'b100101); #1;
    check("few_ready", bus.req_ready, 64'b100101);
    @(posedge clk_i); #1;
    check("few_wb_valid", bus.wb_valid, 64'b0111);
    check("few_wbdata0", bus.wbdata[0], 64'd102);
    check("few_wbdata1", bus.wbdata[1], 64'd105);
    check("few_wbdata2", bus.wbdata[2], 64'd100);
    check("few_rr_ptr", dut.rr_ptr, 64'd1);

    // Reset over a would-be grant
    @(negedge clk_i); rst_i = 1'b1; drive_all('1); #1;
    check("rst2_ready", bus.req_ready, 64'h0);
    @(posedge clk_i); #1;
    check("rst2_wb_valid", bus.wb_valid, 64'h0);
    check("rst2_rr_ptr", dut.rr_ptr, 64'd0);
    check("rst2_wbdata3", bus.wbdata[3], 64'h0);
    check("rst2_ex_valid0", bus.ex[0].valid, 64'd0);
    @(negedge clk_i); rst_i = 1'b0; drive_all('1); #1;
    check("rst2_release_ready", bus.req_ready, 64'b001111);
    @(posedge clk_i); #1;
    check("rst2_release_rr_ptr", dut.rr_ptr, 64'd4);

    // Random traffic, source 2 always valid, results tagged by unique data
    v = '0; seq = 1000; streak = 0; max_streak = 0;
    bad_ready = 0; bad_count = 0; bad_ports = 0; unexpected = 0; lost = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk_i);
      for (int i = 0; i < NR_REQ; i++) begin
        if (!v[i]) begin
          v[i] = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
          if (v[i]) begin
            d[i] = 64'(seq);
            seq++;
          end
        end
        bus.req_valid[i]    = v[i];
        bus.req_trans_id[i] = TRANS_ID_BITS'(i);
        bus.req_data[i]     = d[i];
        bus.req_ex[i]       = '0;
      end
      #1;
      r = bus.req_ready;
      nv = $countones(v);
      exp_q.delete();
      for (int i = 0; i < NR_REQ; i++) begin
        if (r[i]) begin
          if (!v[i]) bad_ready++;
          else exp_q.push_back(d[i]);
          v[i] = 1'b0;
        end
      end
      n = exp_q.size();
      if (n != ((nv < NR_WB_PORTS) ? nv : NR_WB_PORTS)) bad_count++;
      if (r[2]) streak = 0;
      else begin
        streak++;
        if (streak > max_streak) max_streak = streak;
      end
      @(posedge clk_i); #1;
      if (bus.wb_valid != 4'((1 << n) - 1)) bad_ports++;
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        if (bus.wb_valid[k]) begin
          found = 1'b0;
          for (int q = 0; q < exp_q.size(); q++) begin
            if (!found && exp_q[q] == bus.wbdata[k]) begin
              exp_q.delete(q);
              found = 1'b1;
            end
          end
          if (!found) unexpected++;
        end
      end
      lost += exp_q.size();
    end
    check("starve_wait_le_2", 64'(max_streak <= 1), 64'd1);
    check("rand_ready_without_valid", 64'(bad_ready), 64'd0);
    check("rand_grant_count", 64'(bad_count), 64'd0);
    check("rand_port_fill", 64'(bad_ports), 64'd0);
    check("rand_unexpected_or_dup", 64'(unexpected), 64'd0);
    check("rand_lost", 64'(lost), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
